// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register word offsets shared by the GPIO input port
package gpio_pkg;

  localparam int GPIO_DATA = 0;
  localparam int GPIO_RISE = 1;
  localparam int GPIO_FALL = 2;
  localparam int GPIO_MASK = 3;

endpackage

// File: rtl/gpio_input_port_if.sv
// rtl/gpio_input_port_if.sv - word-addressed register bus between core and GPIO input port
interface gpio_input_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output addr, rd_en, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr, rd_en, wr_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - two-stage synchroniser, debounce counter and edge pulses for one pin
module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          toggle;

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    toggle  = 1'b0;
    // Any sample that agrees with the accepted level restarts the stability count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = toggle & ~level_q;
  assign fall  = toggle & level_q;

endmodule

// File: rtl/gpio_input_port.sv
// rtl/gpio_input_port.sv - debounced GPIO inputs with sticky W1C edge flags, edge mask and irq
module gpio_input_port
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  gpio_input_port_if.slave      bus,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] level, rise_p, fall_p;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .pin_in(gpio_in[i]),
      .level (level[i]),
      .rise  (rise_p[i]),
      .fall  (fall_p[i])
    );
  end

  logic [GPIO_WIDTH-1:0] rise_q, rise_d;
  logic [GPIO_WIDTH-1:0] fall_q, fall_d;
  logic [GPIO_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  irq_q, irq_d;
  logic [GPIO_WIDTH-1:0] wr_bits, rise_clr, fall_clr;

  always_comb begin
    wr_bits  = bus.wr_data[GPIO_WIDTH-1:0];
    rise_clr = '0;
    fall_clr = '0;
    mask_d   = mask_q;
    if (bus.wr_en) begin
      if (bus.addr == ADDR_WIDTH'(GPIO_RISE)) rise_clr = wr_bits;
      if (bus.addr == ADDR_WIDTH'(GPIO_FALL)) fall_clr = wr_bits;
      if (bus.addr == ADDR_WIDTH'(GPIO_MASK)) mask_d   = wr_bits;
    end
    // OR-ing the new pulse after the clear lets a fresh edge survive a same-cycle W1C.
    rise_d = (rise_q & ~rise_clr) | rise_p;
    fall_d = (fall_q & ~fall_clr) | fall_p;
    irq_d  = |((rise_q | fall_q) & mask_q);

    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      case (bus.addr)
        ADDR_WIDTH'(GPIO_DATA): rd_data_d = DATA_WIDTH'(level);
        ADDR_WIDTH'(GPIO_RISE): rd_data_d = DATA_WIDTH'(rise_q);
        ADDR_WIDTH'(GPIO_FALL): rd_data_d = DATA_WIDTH'(fall_q);
        ADDR_WIDTH'(GPIO_MASK): rd_data_d = DATA_WIDTH'(mask_q);
        default:                rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_q     <= '0;
      fall_q     <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// tb/tb_gpio_input_port.sv - directed self-checking bench for gpio_input_port
module tb_gpio_input_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_input_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  gpio_input_port #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (8),
    .GPIO_WIDTH     (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .gpio_in(gpio_in),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check_eq("rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    d = bus.rd_data;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bus.addr    = '0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // Reset with pins high
    reset   = 1'b0;
    gpio_in = 8'hFF;
    tick(3);
    check_eq("rst_rd_data", bus.rd_data, 32'h0);
    check_eq("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    gpio_in = 8'h00;
    reset   = 1'b1;
    tick(3);
    bus_rd(8'd0, d); check_eq("rst_data", d, 32'h0);

    // Level 0x05 accepted after 2 + 4 cycles
    gpio_in = 8'h05;
    tick(5);
    bus_rd(8'd0, d); check_eq("data_before_accept", d, 32'h0);
    bus_rd(8'd0, d); check_eq("data_accepted", d, 32'h5);
    tick(1);
    check_eq("rd_valid_low", {31'b0, bus.rd_valid}, 32'h0);
    check_eq("rd_data_hold", bus.rd_data, 32'h5);
    bus_rd(8'd1, d); check_eq("rise_05", d, 32'h5);
    bus_rd(8'd2, d); check_eq("fall_00", d, 32'h0);
    check_eq("irq_unmasked", {31'b0, irq}, 32'h0);

    // Release, clear flags, then a 3-cycle glitch on bit0
    gpio_in = 8'h00;
    tick(8);
    bus_rd(8'd0, d); check_eq("data_low", d, 32'h0);
    bus_rd(8'd2, d); check_eq("fall_05", d, 32'h5);
    bus_wr(8'd1, 32'hFF);
    bus_wr(8'd2, 32'hFF);
    bus_rd(8'd1, d); check_eq("rise_cleared", d, 32'h0);
    bus_rd(8'd2, d); check_eq("fall_cleared", d, 32'h0);
    gpio_in = 8'h01;
    tick(3);
    gpio_in = 8'h00;
    tick(8);
    bus_rd(8'd0, d); check_eq("glitch_data", d, 32'h0);
    bus_rd(8'd1, d); check_eq("glitch_rise", d, 32'h0);

    // Masked rise on bit0 raises irq one cycle after the flag
    bus_wr(8'd3, 32'h1);
    bus_rd(8'd3, d); check_eq("mask_rd", d, 32'h1);
    gpio_in = 8'h01;
    tick(6);
    check_eq("irq_flag_cycle", {31'b0, irq}, 32'h0);
    tick(1);
    check_eq("irq_set", {31'b0, irq}, 32'h1);
    bus_wr(8'd1, 32'h1);
    check_eq("irq_w1c_cycle", {31'b0, irq}, 32'h1);
    tick(1);
    check_eq("irq_dropped", {31'b0, irq}, 32'h0);
    bus_rd(8'd1, d); check_eq("rise_w1c", d, 32'h0);

    // Fall on bit0 also drives irq through the mask
    gpio_in = 8'h00;
    tick(8);
    check_eq("irq_fall", {31'b0, irq}, 32'h1);
    bus_wr(8'd2, 32'h1);
    tick(1);
    check_eq("irq_fall_clr", {31'b0, irq}, 32'h0);

    // W1C of RISE in the same cycle a new rise toggles: set wins
    gpio_in = 8'h01;
    tick(5);
    bus_wr(8'd1, 32'h1);
    bus_rd(8'd1, d); check_eq("set_wins", d, 32'h1);
    bus_wr(8'd1, 32'h1);
    bus_rd(8'd1, d); check_eq("rise_w1c2", d, 32'h0);

    // Upper write bits ignored; read+write same cycle returns the old value
    bus_wr(8'd3, 32'hFFFF_FF03);
    bus_rd(8'd3, d); check_eq("mask_trunc", d, 32'h3);
    bus.addr    = 8'd3;
    bus.wr_data = 32'h0;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    tick(1);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    check_eq("rdwr_pre", bus.rd_data, 32'h3);
    bus_rd(8'd3, d); check_eq("rdwr_post", d, 32'h0);

    // Unmapped address and writes to read-only DATA
    bus_rd(8'd7, d); check_eq("unmapped", d, 32'h0);
    bus_wr(8'd0, 32'hFF);
    bus_rd(8'd0, d); check_eq("data_ro", d, 32'h1);

    // Reset mid-debounce restarts the count from scratch
    gpio_in = 8'h03;
    tick(4);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    bus_rd(8'd0, d); check_eq("midrst_early", d, 32'h0);
    tick(3);
    bus_rd(8'd0, d); check_eq("midrst_before", d, 32'h0);
    bus_rd(8'd0, d); check_eq("midrst_after", d, 32'h3);
    bus_rd(8'd1, d); check_eq("midrst_rise", d, 32'h3);
    check_eq("midrst_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
